uart_tx_scheduler: RTL and testbench

- Shares one 7-bit UART transmitter between NUM_REQ requesters (e.g. clock display, status reporter, debug echo).
- Arbitrates round-robin and latches the winning character.
- Launches the transmitter with an active-low go strobe.
- Holds the bus stable for a full frame plus an inter-frame guard gap, then services the next requester.

---
 rtl/uart_tx_scheduler_if.sv | 24 ++
 rtl/uart_tx_scheduler.sv | 152 +++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// Bus between the requesters/transmitter and the UART transmit scheduler.
// The scheduler takes the slave side; whoever drives requests takes the master side.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   i_req;
    logic [7*NUM_REQ-1:0] i_data;
    logic                 i_tx_done;
    logic [NUM_REQ-1:0]   o_ack;
    logic [2:0]           o_grant_id;
    logic                 o_busy;
    logic                 o_tx_go;
    logic [8:0]           o_tx_din;

    modport slave (
        input  i_req, i_data, i_tx_done,
        output o_ack, o_grant_id, o_busy, o_tx_go, o_tx_din
    );

    modport master (
        output i_req, i_data, i_tx_done,
        input  o_ack, o_grant_id, o_busy, o_tx_go, o_tx_din
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one 7-bit UART transmitter between NUM_REQ requesters.
// Each grant launches one frame, then the bus is held for the frame plus a guard gap.
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int FRAME_CYCLES = 10,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    uart_tx_scheduler_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_GAP
    } state_e;

    localparam logic [7:0] FRAME_LOAD = 8'(FRAME_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

    state_e               state_q, state_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [2:0]           rr_q, rr_d;
    logic [2:0]           grant_q, grant_d;
    logic [8:0]           din_q, din_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 tx_go_q, tx_go_d;

    logic                 req_any;
    logic                 hi_found;
    logic [2:0]           hi_idx;
    logic [2:0]           lo_idx;
    logic [2:0]           winner;
    logic [6:0]           winner_char;

    // Round-robin pick: lowest requester at or above the pointer, else lowest overall.
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        req_any  = |bus.i_req;
        hi_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.i_req[k]) begin
                lo_idx = 3'(k);
            end
            if (bus.i_req[k] && (k >= int'(rr_q))) begin
                hi_idx   = 3'(k);
                hi_found = 1'b1;
            end
        end
        winner = hi_found ? hi_idx : lo_idx;

        winner_char = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == 3'(k)) begin
                winner_char = bus.i_data[7*k +: 7];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        grant_d = grant_q;
        din_d   = din_q;
        ack_d   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_any) begin
                    state_d = ST_LOAD;
                    grant_d = winner;
                    din_d   = {2'b00, winner_char};
                    ack_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
                    rr_d    = (winner == 3'(NUM_REQ - 1)) ? 3'd0 : winner + 3'd1;
                end
            end

            ST_LOAD: begin
                state_d = ST_SEND;
                cnt_d   = FRAME_LOAD;
            end

            // An early done from the transmitter shortens the frame but never the gap.
            ST_SEND: begin
                if ((cnt_q == 8'd0) || bus.i_tx_done) begin
                    if (GAP_CYCLES == 0) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            ST_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered off the next state so the strobe is glitch-free.
        tx_go_d = (state_d != ST_LOAD);
        busy_d  = (state_d != ST_IDLE);
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            grant_q <= '0;
            din_q   <= '0;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            tx_go_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            tx_go_q <= tx_go_d;
        end
    end

    assign bus.o_ack      = ack_q;
    assign bus.o_grant_id = grant_q;
    assign bus.o_busy     = busy_q;
    assign bus.o_tx_go    = tx_go_q;
    assign bus.o_tx_din   = din_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: a frame-timeline model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_uart_tx_scheduler;

    localparam int NREQ  = 4;
    localparam int FRAME = 10;
    localparam int GAP_A = 2;
    localparam int GAP_B = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NUM_REQ(NREQ)) ifa ();
    uart_tx_scheduler_if #(.NUM_REQ(NREQ)) ifb ();

    uart_tx_scheduler #(.NUM_REQ(NREQ), .FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP_A)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifa)
    );

    uart_tx_scheduler #(.NUM_REQ(NREQ), .FRAME_CYCLES(FRAME), .GAP_CYCLES(GAP_B)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifb)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: time elapsed since the launch cycle (t=0 is the go-low cycle) decides everything.
    typedef struct {
        bit         active;
        int         t;
        int         send_len;
        int         rr;
        int         grant;
        logic [8:0] din;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.active = 1'b0; r.t = 0; r.send_len = 0; r.rr = 0; r.grant = 0; r.din = '0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(mdl_t s, logic [NREQ-1:0] req, logic [7*NREQ-1:0] data,
                                      logic done, int gap);
        mdl_t n = s;
        bit   found = 1'b0;
        int   j;
        if (s.active) begin
            if (s.t >= 1 && s.t <= s.send_len && done) n.send_len = s.t;
            n.t = s.t + 1;
            if (n.t >= 1 + n.send_len + gap) n.active = 1'b0;
        end else begin
            for (int k = 0; k < NREQ; k++) begin
                j = (s.rr + k) % NREQ;
                if (!found && req[j]) begin
                    found      = 1'b1;
                    n.active   = 1'b1;
                    n.t        = 0;
                    n.send_len = FRAME;
                    n.grant    = j;
                    n.din      = {2'b00, data[7*j +: 7]};
                    n.rr       = (j + 1) % NREQ;
                end
            end
        end
        return n;
    endfunction

    mdl_t m_a, m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_a <= mdl_reset();
            m_b <= mdl_reset();
        end else begin
            m_a <= mdl_step(m_a, ifa.i_req, ifa.i_data, ifa.i_tx_done, GAP_A);
            m_b <= mdl_step(m_b, ifb.i_req, ifb.i_data, ifb.i_tx_done, GAP_B);
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string tag, input mdl_t m, input logic [NREQ-1:0] ack,
                       input logic go, input logic busy, input logic [2:0] gid, input logic [8:0] din);
        bit              launch;
        logic [NREQ-1:0] e_ack;
        launch = m.active && (m.t == 0);
        e_ack  = launch ? NREQ'(1 << m.grant) : '0;
        check({tag, "_ack"},   32'(ack),  32'(e_ack));
        check({tag, "_go"},    32'(go),   32'(!launch));
        check({tag, "_busy"},  32'(busy), 32'(m.active));
        check({tag, "_grant"}, 32'(gid),  32'(m.grant));
        check({tag, "_din"},   32'(din),  32'(m.din));
    endtask

    always @(negedge clk) begin
        cmp("a", m_a, ifa.o_ack, ifa.o_tx_go, ifa.o_busy, ifa.o_grant_id, ifa.o_tx_din);
        cmp("b", m_b, ifb.o_ack, ifb.o_tx_go, ifb.o_busy, ifb.o_grant_id, ifb.o_tx_din);
    end

    // Event logs for the directed scenarios.
    int         launch_q[$];
    int         ack_q[$];
    int         busy_run_q[$];
    logic [8:0] din_q[$];
    int         busy_run = 0;
    int         launch_b_q[$];
    int         low_b_q[$];
    bit         win_b = 1'b0;
    bit         seen_hi_b = 1'b0;
    int         low_b = 0;

    always @(negedge clk) begin
        if (!ifa.o_tx_go) begin
            launch_q.push_back(cyc);
            din_q.push_back(ifa.o_tx_din);
        end
        for (int k = 0; k < NREQ; k++) if (ifa.o_ack[k]) ack_q.push_back(k);
        if (ifa.o_busy) busy_run++;
        else if (busy_run > 0) begin
            busy_run_q.push_back(busy_run);
            busy_run = 0;
        end
        if (win_b) begin
            if (!ifb.o_tx_go) launch_b_q.push_back(cyc);
            if (ifb.o_busy) begin
                if (low_b > 0) low_b_q.push_back(low_b);
                low_b     = 0;
                seen_hi_b = 1'b1;
            end else if (seen_hi_b) begin
                low_b++;
            end
        end
    end

    task automatic clear_logs();
        launch_q.delete(); ack_q.delete(); busy_run_q.delete(); din_q.delete();
        busy_run = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    task automatic wait_launch(input int budget);
        int n = 0;
        @(negedge clk);
        while (ifa.o_tx_go && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("launch_seen", 32'(ifa.o_tx_go), 32'(0));
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (ifa.o_busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("busy_drops", 32'(ifa.o_busy), 32'(0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int exp_ord [5] = '{0, 1, 2, 3, 0};

        ifa.i_req = '0; ifa.i_data = '0; ifa.i_tx_done = 1'b0;
        ifb.i_req = 4'b0001; ifb.i_data = {4{7'h55}}; ifb.i_tx_done = 1'b0;
        #1 rst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_go",    32'(ifa.o_tx_go),    32'(1));
        check("rst_busy",  32'(ifa.o_busy),     32'(0));
        check("rst_ack",   32'(ifa.o_ack),      32'(0));
        check("rst_din",   32'(ifa.o_tx_din),   32'(0));
        check("rst_grant", 32'(ifa.o_grant_id), 32'(0));
        @(posedge clk);
        #3 rst = 1'b0;

        // 1: single request from requester 2
        tick();
        clear_logs();
        ifa.i_data[20:14] = 7'h41;
        ifa.i_req = 4'b0100;
        wait_launch(20);
        check("t1_ack",   32'(ifa.o_ack),      32'(4'b0100));
        check("t1_din",   32'(ifa.o_tx_din),   32'(9'h041));
        check("t1_grant", 32'(ifa.o_grant_id), 32'(2));
        tick();
        ifa.i_req = '0;
        wait_idle(40);
        tick();
        check("t1_busy_len", 32'(busy_run_q.size() > 0 ? busy_run_q[0] : 0), 32'(13));

        // 2: all four requesting; 6: dut_b (no gap) observed over the same window
        do_reset();
        clear_logs();
        ifa.i_data = {7'h44, 7'h43, 7'h42, 7'h41};
        tick();
        win_b = 1'b1;
        ifa.i_req = 4'b1111;
        n = 0;
        while (launch_q.size() < 5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        tick();
        ifa.i_req = '0;
        win_b = 1'b0;
        check("t2_launches", 32'(launch_q.size()), 32'(5));
        for (int i = 0; i < 5; i++) begin
            if (i < ack_q.size()) check("t2_order", 32'(ack_q[i]), 32'(exp_ord[i]));
            if (i < din_q.size()) check("t2_char", 32'(din_q[i]), 32'(9'h041 + 9'(exp_ord[i])));
            if (i > 0 && i < launch_q.size())
                check("t2_spacing", 32'(launch_q[i] - launch_q[i-1]), 32'(14));
        end
        check("t6_enough_launches", 32'(launch_b_q.size() >= 3), 32'(1));
        for (int i = 1; i < launch_b_q.size(); i++)
            check("t6_spacing", 32'(launch_b_q[i] - launch_b_q[i-1]), 32'(12));
        check("t6_enough_gaps", 32'(low_b_q.size() >= 2), 32'(1));
        foreach (low_b_q[i]) check("t6_idle_len", 32'(low_b_q[i]), 32'(1));
        wait_idle(40);
        tick();

        // 3: early done on the third SEND cycle
        do_reset();
        clear_logs();
        tick();
        ifa.i_req = 4'b0001;
        wait_launch(20);
        tick();
        tick();
        tick();
        ifa.i_tx_done = 1'b1;
        tick();
        ifa.i_tx_done = 1'b0;
        n = 0;
        while (launch_q.size() < 2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        tick();
        ifa.i_req = '0;
        wait_idle(40);
        tick();
        // LOAD + 3 SEND + 2 GAP busy cycles, then one IDLE cycle before the relaunch.
        check("t3_busy_len", 32'(busy_run_q.size() > 0 ? busy_run_q[0] : 0), 32'(6));
        check("t3_relaunch", 32'(launch_q.size() > 1 ? launch_q[1] - launch_q[0] : 0), 32'(7));

        // 4: request raised and dropped entirely while busy
        do_reset();
        clear_logs();
        tick();
        ifa.i_req = 4'b0001;
        wait_launch(20);
        tick();
        ifa.i_req = '0;
        tick();
        tick();
        ifa.i_req = 4'b0010;
        repeat (5) tick();
        ifa.i_req = '0;
        wait_idle(40);
        repeat (10) tick();
        check("t4_acks",     32'(ack_q.size()),    32'(1));
        check("t4_ack_id",   32'(ack_q.size() > 0 ? ack_q[0] : 9), 32'(0));
        check("t4_launches", 32'(launch_q.size()), 32'(1));

        // 5: asynchronous reset mid-frame
        do_reset();
        tick();
        ifa.i_req = 4'b0001;
        wait_launch(20);
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("t5_go",    32'(ifa.o_tx_go),    32'(1));
        check("t5_busy",  32'(ifa.o_busy),     32'(0));
        check("t5_ack",   32'(ifa.o_ack),      32'(0));
        check("t5_grant", 32'(ifa.o_grant_id), 32'(0));
        ifa.i_req = 4'b1010;
        clear_logs();
        @(posedge clk);
        #3 rst = 1'b0;
        wait_launch(20);
        check("t5_first_ack",   32'(ifa.o_ack),      32'(4'b0010));
        check("t5_first_grant", 32'(ifa.o_grant_id), 32'(1));
        tick();
        ifa.i_req = '0;
        wait_idle(40);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
